scan_index_gen: RTL and testbench
=================================

# scan_index_gen

Channel-scan sequencer that feeds the 4-to-16 decoder stage: it produces a 4-bit channel index plus a decoder enable and steps through channels 0..15 with a programmable dwell time per channel. It handles single-sweep and continuous scanning, optional skipping of masked-off channels, and a start/busy/done/abort handshake towards the controlling logic. Its `idx` and `en` outputs connect directly to the decoder's select and enable inputs, so at most one decoded line is active at any time.

## Interface
- `DWELL_W`, default 8: width of the dwell-count input.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  begins a sweep; sampled only in IDLE.
- `abort`  in  1  ends the scan immediately; honoured in any state.
- `continuous`  in  1  when high, the scan wraps to the first enabled channel after the last one; sampled live.
- `dwell`  in  DWELL_W  each channel is held for dwell+1 cycles; latched at start.
- `mask`  in  16  bit k=1 means channel k is scanned; latched at start.
- `idx`  out  4  current channel index, fed to the decoder select.
- `en`  out  1  decoder enable; high while a channel is held.
- `step`  out  1  one-cycle pulse in the first cycle of each channel.
- `busy`  out  1  high outside IDLE.
- `done`  out  1  one-cycle pulse when a sweep finishes normally.

## Operation
- States: IDLE and DWELL.
- Reset values: `idx`=0, `en`=0, `step`=0, `busy`=0, `done`=0; state=IDLE; dwell counter=0.
- IDLE, `start`=1, `abort`=0:
  - latch `mask` into `mask_q` and `dwell` into `dwell_q`.
  - if `mask_q` would be 0: pulse `done` next cycle and stay in IDLE.
  - otherwise load `idx` with the lowest set bit, enter DWELL, and assert `en`, `busy` and `step`.
- DWELL:
  - the counter counts 0..`dwell_q`.
  - at terminal count, find the next set bit of `mask_q` strictly above `idx`.
  - if one is found: load it, clear the counter, pulse `step`.
  - if none is found and `continuous`=1: load the lowest set bit (wrap), pulse `step`.
  - if none is found and `continuous`=0: go to IDLE, drop `en`, pulse `done`. `idx` holds its last value.
- The next-channel search is a combinational priority find over 16 bits. There are no gap cycles between channels, and `en` stays high across channel changes.
- `abort`=1 in any state: next cycle the block is in IDLE with `en`=0, `busy`=0 and `step`=0. `done` is not pulsed and `idx` holds.
- `start` and `abort` both high in IDLE: `abort` wins and the block stays in IDLE.
- `start` while busy: ignored.
- Changes to `mask` or `dwell` mid-scan have no effect until the next start.
- `rst` mid-scan: the block returns to reset values on the next edge, overriding everything else.

## Timing
- `start` sampled at edge N: `idx`, `en`, `step` and `busy` are valid after edge N+1 (latency 1).
- Each channel occupies exactly `dwell_q`+1 cycles. `step` is high in the first of those cycles.
- With `continuous`=0 and C enabled channels, `busy` is high for C·(`dwell_q`+1) cycles. `done` pulses in the first IDLE cycle after that.
- `continuous` is evaluated only at the terminal count of the last enabled channel.
- A new `start` is accepted in the same cycle that `done` is high. The block is already in IDLE then.

## Configuration
- `SCAN_SKIP_MASK_EN` defined: the behaviour is as described above, and `mask` is honoured.
- `SCAN_SKIP_MASK_EN` undefined:
  - the `mask` port remains but is ignored, and `mask_q` is treated as 16'hFFFF.
  - the priority search reduces to `idx`+1 with wrap from 15 to 0.
  - the mask==0 early-done path does not exist.

## Structure
- Package `scan_pkg` holds:
  - the state enum `scan_state_t` (IDLE, DWELL).
  - `SCAN_CH = 16` and `SCAN_IDX_W = 4`.
  - the function `next_set_bit(mask, from)`, returning a found flag and an index.
- Sub-module `dwell_counter` holds the dwell-time counter:
  - inputs: `clk`, `rst`, `clr`, `limit[DWELL_W-1:0]`.
  - output: the terminal-count pulse `tc`.
  - the top level holds the FSM and the index register.

## Test plan
- Reset check: assert `rst` mid-scan at `idx`=5 → next cycle `idx`=0, `en`=0, `busy`=0, no `done` pulse.
- Full single sweep: `mask`=16'hFFFF, `dwell`=0, `continuous`=0, pulse `start` → `idx` runs 0..15 in 16 consecutive cycles, `step` is high every cycle, and `done` pulses at cycle 17.
- Skip and dwell: `mask`=16'h8421, `dwell`=2 → `idx` holds 0, 5, 10, 15 for 3 cycles each, `busy` is high for 12 cycles, then `done` pulses. Without `SCAN_SKIP_MASK_EN`, `busy` is high for 48 cycles instead.
- Continuous wrap: `mask`=16'h0006, `dwell`=1, `continuous`=1 → `idx` sequence 1,1,2,2,1,1,2,2… with no `en` gap. Dropping `continuous` during channel 1 ends the scan after channel 2, followed by a `done` pulse.
- Abort and start priority:
  - `abort` during channel 3 → IDLE next cycle, `done`=0, `idx`=3.
  - `start` and `abort` in the same cycle → the block stays in IDLE.
  - `start` while busy → ignored.
- Empty mask: `mask`=16'h0000 with `start` → `en` never rises, `busy` stays 0, and `done` pulses one cycle after `start`.

Source files
------------

// File: rtl/scan_pkg.sv
// Shared types and helpers for the channel-scan sequencer.
// Provides the FSM state enum, channel geometry and the next-set-bit priority find.
package scan_pkg;

  localparam int SCAN_CH    = 16;
  localparam int SCAN_IDX_W = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    DWELL = 1'b1
  } scan_state_t;

  typedef struct packed {
    logic                  found;
    logic [SCAN_IDX_W-1:0] idx;
  } nsb_t;

  // Lowest set bit of mask at a position >= from; from may be SCAN_CH (nothing found).
  function automatic nsb_t next_set_bit(input logic [SCAN_CH-1:0] mask,
                                        input logic [SCAN_IDX_W:0]  from);
    nsb_t r;
    r = '0;
    for (int k = SCAN_CH - 1; k >= 0; k--) begin
      if (mask[k] && (k >= int'(from))) begin
        r.found = 1'b1;
        r.idx   = SCAN_IDX_W'(k);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/dwell_counter.sv
// Per-channel dwell timer: counts 0..limit and pulses tc on the last count, then restarts at 0.
// Latency: tc is combinational from the count register; clr holds the count at 0 (no backpressure).
module dwell_counter #(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic [DWELL_W-1:0] limit,
  output logic               tc
);

  logic [DWELL_W-1:0] cnt_q, cnt_d;

  assign tc = !clr && (cnt_q == limit);

  always_comb begin
    cnt_d = cnt_q + DWELL_W'(1);
    if (clr || tc) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/scan_index_gen.sv
// Channel-scan sequencer driving a 4-to-16 decoder; outputs registered, start-to-first-channel latency 1, no backpressure.
// SCAN_SKIP_MASK_EN: when defined, masked-off channels are skipped; otherwise all 16 channels are scanned.
module scan_index_gen
  import scan_pkg::*;
#(
  parameter int DWELL_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  continuous,
  input  logic [DWELL_W-1:0]    dwell,
  input  logic [SCAN_CH-1:0]    mask,
  output logic [SCAN_IDX_W-1:0] idx,
  output logic                  en,
  output logic                  step,
  output logic                  busy,
  output logic                  done
);

  scan_state_t           state_q, state_d;
  logic [SCAN_IDX_W-1:0] idx_q, idx_d;
  logic                  step_q, step_d;
  logic                  done_q, done_d;
  logic [DWELL_W-1:0]    dwell_q, dwell_d;
  logic [SCAN_CH-1:0]    mask_eff;
  logic [SCAN_CH-1:0]    mask_start;
  logic [SCAN_IDX_W:0]   idx_from;
  logic                  tc;
  nsb_t                  first_start, nxt_up, first_wrap;

`ifdef SCAN_SKIP_MASK_EN
  logic [SCAN_CH-1:0] mask_q, mask_d;
  assign mask_eff   = mask_q;
  assign mask_start = mask;
`else
  logic unused_mask;
  assign unused_mask = ^mask;
  assign mask_eff    = '1;
  assign mask_start  = '1;
`endif

  // Three parallel searches: first channel of a new sweep, next channel up, and wrap target.
  assign idx_from    = {1'b0, idx_q} + 5'd1;
  assign first_start = next_set_bit(mask_start, '0);
  assign nxt_up      = next_set_bit(mask_eff, idx_from);
  assign first_wrap  = next_set_bit(mask_eff, '0);

  dwell_counter #(
    .DWELL_W (DWELL_W)
  ) u_dwell_counter (
    .clk   (clk),
    .rst   (rst),
    .clr   (state_q != DWELL),
    .limit (dwell_q),
    .tc    (tc)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    step_d  = 1'b0;
    done_d  = 1'b0;
    dwell_d = dwell_q;
`ifdef SCAN_SKIP_MASK_EN
    mask_d  = mask_q;
`endif
    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          dwell_d = dwell;
`ifdef SCAN_SKIP_MASK_EN
          mask_d  = mask;
`endif
          if (first_start.found) begin
            state_d = DWELL;
            idx_d   = first_start.idx;
            step_d  = 1'b1;
          end
`ifdef SCAN_SKIP_MASK_EN
          else begin
            done_d = 1'b1;
          end
`endif
        end
      end
      DWELL: begin
        if (abort) begin
          state_d = IDLE;
        end else if (tc) begin
          if (nxt_up.found) begin
            idx_d  = nxt_up.idx;
            step_d = 1'b1;
          end else if (continuous && first_wrap.found) begin
            idx_d  = first_wrap.idx;
            step_d = 1'b1;
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      step_q  <= 1'b0;
      done_q  <= 1'b0;
      dwell_q <= '0;
`ifdef SCAN_SKIP_MASK_EN
      mask_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      step_q  <= step_d;
      done_q  <= done_d;
      dwell_q <= dwell_d;
`ifdef SCAN_SKIP_MASK_EN
      mask_q  <= mask_d;
`endif
    end
  end

  // The decoder is enabled exactly while a channel is being held.
  assign busy = (state_q == DWELL);
  assign en   = busy;
  assign idx  = idx_q;
  assign step = step_q;
  assign done = done_q;

endmodule

// File: tb/tb_scan_index_gen.sv
// Directed self-checking bench for scan_index_gen; expectations follow SCAN_SKIP_MASK_EN when defined.
module tb_scan_index_gen;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          abort;
  logic          continuous;
  logic [DW-1:0] dwell;
  logic [15:0]   mask;
  logic [3:0]    idx;
  logic          en;
  logic          step;
  logic          busy;
  logic          done;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  scan_index_gen #(
    .DWELL_W (DW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .continuous (continuous),
    .dwell      (dwell),
    .mask       (mask),
    .idx        (idx),
    .en         (en),
    .step       (step),
    .busy       (busy),
    .done       (done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cyc;
    rst = 1'b1; start = 1'b0; abort = 1'b0; continuous = 1'b0; dwell = '0; mask = '0;
    tick(); tick();
    chk("rst_idx",  32'(idx),  0);
    chk("rst_en",   32'(en),   0);
    chk("rst_step", 32'(step), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    rst = 1'b0;
    tick();

    // Full single sweep, dwell 0
    mask = 16'hFFFF; dwell = 0; continuous = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      chk("sweep_idx",  32'(idx),  i);
      chk("sweep_step", 32'(step), 1);
      chk("sweep_en",   32'(en),   1);
      tick();
    end
    chk("sweep_done",      32'(done), 1);
    chk("sweep_busy_end",  32'(busy), 0);
    chk("sweep_idx_hold",  32'(idx),  15);
    // restart in the done cycle
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("restart_busy", 32'(busy), 1);
    chk("restart_idx",  32'(idx),  0);
    chk("restart_step", 32'(step), 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("restart_abort_busy", 32'(busy), 0);
    tick();

    // Skip and dwell; mid-scan mask/dwell changes are ignored
    mask = 16'h8421; dwell = 2; start = 1'b1;
    tick();
    start = 1'b0; mask = 16'h0000; dwell = 7;
    cyc = 0;
    while (busy && cyc < 100) begin
`ifdef SCAN_SKIP_MASK_EN
      chk("skip_idx", 32'(idx), 5 * (cyc / 3));
`else
      chk("skip_idx", 32'(idx), cyc / 3);
`endif
      chk("skip_step", 32'(step), 32'(cyc % 3 == 0));
      tick();
      cyc++;
    end
`ifdef SCAN_SKIP_MASK_EN
    chk("skip_busy_cycles", cyc, 12);
`else
    chk("skip_busy_cycles", cyc, 48);
`endif
    chk("skip_done", 32'(done), 1);
    chk("skip_idx_hold", 32'(idx), 15);
    tick();
    chk("skip_done_clear", 32'(done), 0);

    // Continuous wrap, then drop continuous mid-scan
    mask = 16'h0006; dwell = 1; continuous = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    begin
`ifdef SCAN_SKIP_MASK_EN
      int n_run = 8;
`else
      int n_run = 36;
`endif
      for (int c = 0; c < n_run; c++) begin
`ifdef SCAN_SKIP_MASK_EN
        chk("cont_idx", 32'(idx), ((c / 2) % 2 == 0) ? 1 : 2);
`else
        chk("cont_idx", 32'(idx), (c / 2) % 16);
`endif
        chk("cont_en", 32'(en), 1);
        tick();
      end
      continuous = 1'b0;
      cyc = n_run;
      while (busy && cyc < 200) begin
        tick();
        cyc++;
      end
    end
`ifdef SCAN_SKIP_MASK_EN
    chk("cont_end_cycle", cyc, 12);
    chk("cont_end_idx", 32'(idx), 2);
`else
    chk("cont_end_cycle", cyc, 64);
    chk("cont_end_idx", 32'(idx), 15);
`endif
    chk("cont_done", 32'(done), 1);
    tick();

    // Start while busy ignored, then abort during channel 3
    mask = 16'hFFFF; dwell = 3; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    start = 1'b1; mask = 16'h0001; dwell = 0;
    tick();
    start = 1'b0;
    chk("busy_start_idx",  32'(idx),  0);
    chk("busy_start_step", 32'(step), 0);
    chk("busy_start_busy", 32'(busy), 1);
    repeat (9) tick();
    chk("ch3_idx",  32'(idx),  3);
    chk("ch3_step", 32'(step), 1);
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_en",   32'(en),   0);
    chk("abort_step", 32'(step), 0);
    chk("abort_done", 32'(done), 0);
    chk("abort_idx",  32'(idx),  3);
    tick();
    chk("abort_done_later", 32'(done), 0);

    // start and abort together: abort wins
    mask = 16'hFFFF; start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    chk("sa_busy", 32'(busy), 0);
    chk("sa_en",   32'(en),   0);
    chk("sa_done", 32'(done), 0);
    tick();
    chk("sa_busy_later", 32'(busy), 0);

    // Empty mask
    mask = 16'h0000; dwell = 0; start = 1'b1;
    tick();
    start = 1'b0;
`ifdef SCAN_SKIP_MASK_EN
    chk("empty_done", 32'(done), 1);
    chk("empty_busy", 32'(busy), 0);
    chk("empty_en",   32'(en),   0);
    tick();
    chk("empty_done_clear", 32'(done), 0);
    chk("empty_busy_later", 32'(busy), 0);
`else
    chk("empty_busy", 32'(busy), 1);
    chk("empty_idx",  32'(idx),  0);
    chk("empty_done", 32'(done), 0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
`endif

    // Reset mid-scan at idx 5
    mask = 16'hFFFF; dwell = 0; continuous = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    chk("mid_idx", 32'(idx), 5);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_idx",  32'(idx),  0);
    chk("mid_rst_en",   32'(en),   0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_step", 32'(step), 0);
    chk("mid_rst_done", 32'(done), 0);
    tick();
    chk("mid_rst_done_later", 32'(done), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
